sonar_scheduler: RTL and testbench

Round-robin sequencer that shares one I2C sonar ranging engine between up to `N_SONAR` sonars on the same bus. It launches one ranging at a time on consecutive 7-bit addresses and enforces the minimum ranging period. Each result is latched into a per-sonar result register with valid and timeout flags. The block sits between the I2C sonar engine and the SPI readout mux, which reads results through a registered index port.

---
 rtl/sonar_sched_pkg.sv | 23 ++
 rtl/rr_next_slot.sv | 32 +++
 rtl/sonar_scheduler.sv | 175 +++++++++++++++++
 tb/tb_sonar_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_sched_pkg.sv
// rtl/sonar_sched_pkg.sv - shared types and constants for the sonar scheduler
package sonar_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    ADVANCE = 2'd3
  } sched_state_t;

  // rd_data field layout: {err, valid, 14'b0, dist}
  localparam int ERR_BIT   = 31;
  localparam int VALID_BIT = 30;
  localparam int DIST_LSB  = 0;
  localparam int DIST_W    = 16;

  // Defaults for a 50 MHz clock: 70 ms ranging period, 100 ms timeout
  localparam int         DEF_N_SONAR        = 4;
  localparam logic [6:0] DEF_ADDR_BASE      = 7'h70;
  localparam int         DEF_RANGE_CYCLES   = 3_500_000;
  localparam int         DEF_TIMEOUT_CYCLES = 5_000_000;

endpackage

// File: rtl/rr_next_slot.sv
// rtl/rr_next_slot.sv - round-robin finder for the next enabled sonar slot
module rr_next_slot #(
  parameter int N_SONAR = 4,
  parameter int IW      = (N_SONAR > 1) ? $clog2(N_SONAR) : 1
) (
  input  logic [N_SONAR-1:0] mask,
  input  logic [IW-1:0]      cur,
  output logic [IW-1:0]      nxt,
  output logic               wrap,
  output logic               found
);

  logic [IW-1:0] probe;

  // Scan from the farthest candidate back to the nearest so the first enabled
  // slot after cur wins; offset N_SONAR lands on cur itself (single-slot case).
  always_comb begin
    nxt   = '0;
    wrap  = 1'b0;
    found = 1'b0;
    probe = '0;
    for (int k = N_SONAR; k >= 1; k--) begin
      probe = IW'((int'(cur) + k) % N_SONAR);
      if (mask[probe]) begin
        nxt   = probe;
        wrap  = (int'(cur) + k) >= N_SONAR;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sonar_scheduler.sv
// rtl/sonar_scheduler.sv - round-robin sequencer sharing one I2C sonar engine
module sonar_scheduler
  import sonar_sched_pkg::*;
#(
  parameter int         N_SONAR        = DEF_N_SONAR,
  parameter logic [6:0] ADDR_BASE      = DEF_ADDR_BASE,
  parameter int         RANGE_CYCLES   = DEF_RANGE_CYCLES,
  parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int        IW             = (N_SONAR > 1) ? $clog2(N_SONAR) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SONAR-1:0] enable_mask,
  output logic               eng_launch,
  output logic [6:0]         eng_addr,
  input  logic               eng_done,
  input  logic [15:0]        eng_dist,
  input  logic [IW-1:0]      rd_idx,
  output logic [31:0]        rd_data,
  output logic [IW-1:0]      cur_slot,
  output logic               frame_done
);

  localparam int            CW           = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] RANGE_LAST   = CW'(RANGE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  sched_state_t state_q, state_d;
  logic [IW-1:0] cur_slot_q, cur_slot_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          got_q, got_d;
  logic          eng_launch_q, eng_launch_d;
  logic [6:0]    eng_addr_q, eng_addr_d;
  logic          frame_done_q, frame_done_d;
  logic [31:0]   rd_data_q, rd_data_d;

  logic [N_SONAR-1:0][DIST_W-1:0] dist_q, dist_d;
  logic [N_SONAR-1:0]             valid_q, valid_d;
  logic [N_SONAR-1:0]             err_q, err_d;

  logic [IW-1:0] search_cur, search_nxt;
  logic          search_wrap, search_found;
  logic          done_take;

  // From IDLE, searching after the top slot yields the lowest enabled slot.
  assign search_cur = (state_q == IDLE) ? IW'(N_SONAR - 1) : cur_slot_q;

  rr_next_slot #(
    .N_SONAR (N_SONAR),
    .IW      (IW)
  ) u_next_slot (
    .mask  (enable_mask),
    .cur   (search_cur),
    .nxt   (search_nxt),
    .wrap  (search_wrap),
    .found (search_found)
  );

  // Sequencer next-state: launch, wait for result or timeout, advance.
  always_comb begin
    state_d      = state_q;
    cur_slot_d   = cur_slot_q;
    cnt_d        = cnt_q;
    got_d        = got_q;
    eng_launch_d = 1'b0;
    eng_addr_d   = eng_addr_q;
    frame_done_d = 1'b0;
    dist_d       = dist_q;
    valid_d      = valid_q;
    err_d        = err_q;
    done_take    = 1'b0;

    case (state_q)
      IDLE: begin
        if (search_found) begin
          cur_slot_d   = search_nxt;
          eng_addr_d   = ADDR_BASE + 7'(search_nxt);
          eng_launch_d = 1'b1;
          state_d      = LAUNCH;
        end
      end

      LAUNCH: begin
        cnt_d   = '0;
        got_d   = 1'b0;
        state_d = WAIT;
      end

      WAIT: begin
        cnt_d     = cnt_q + 1'b1;
        done_take = eng_done && !got_q;
        if (done_take) begin
          dist_d[cur_slot_q]  = eng_dist;
          valid_d[cur_slot_q] = 1'b1;
          err_d[cur_slot_q]   = 1'b0;
          got_d               = 1'b1;
        end
        if (got_q && (cnt_q >= RANGE_LAST)) begin
          state_d = ADVANCE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          // A result arriving in the final cycle still counts as an answer.
          state_d = ADVANCE;
          if (!done_take) begin
            err_d[cur_slot_q]   = 1'b1;
            valid_d[cur_slot_q] = 1'b0;
          end
        end
        // Hold the counter on exit so it never rolls over.
        if (state_d == ADVANCE) begin
          cnt_d = cnt_q;
        end
      end

      ADVANCE: begin
        if (search_found) begin
          cur_slot_d   = search_nxt;
          eng_addr_d   = ADDR_BASE + 7'(search_nxt);
          eng_launch_d = 1'b1;
          frame_done_d = search_wrap;
          state_d      = LAUNCH;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Readout word from stored results only, so fresh results appear one cycle later.
  always_comb begin
    rd_data_d = '0;
    if (int'(rd_idx) < N_SONAR) begin
      rd_data_d[ERR_BIT]               = err_q[rd_idx];
      rd_data_d[VALID_BIT]             = valid_q[rd_idx];
      rd_data_d[DIST_LSB +: DIST_W]    = dist_q[rd_idx];
    end
  end

  // State, registered outputs and result storage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cur_slot_q   <= '0;
      cnt_q        <= '0;
      got_q        <= 1'b0;
      eng_launch_q <= 1'b0;
      eng_addr_q   <= ADDR_BASE;
      frame_done_q <= 1'b0;
      rd_data_q    <= '0;
      dist_q       <= '0;
      valid_q      <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      cur_slot_q   <= cur_slot_d;
      cnt_q        <= cnt_d;
      got_q        <= got_d;
      eng_launch_q <= eng_launch_d;
      eng_addr_q   <= eng_addr_d;
      frame_done_q <= frame_done_d;
      rd_data_q    <= rd_data_d;
      dist_q       <= dist_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign eng_launch = eng_launch_q;
  assign eng_addr   = eng_addr_q;
  assign cur_slot   = cur_slot_q;
  assign frame_done = frame_done_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_sonar_scheduler.sv
// tb/tb_sonar_scheduler.sv - scoreboard bench for sonar_scheduler
`timescale 1ns/1ps
module tb_sonar_scheduler;

  localparam int N      = 4;
  localparam int RC     = 20;
  localparam int TC     = 50;
  localparam int GAP_OK = RC + 2;
  localparam int GAP_TO = TC + 2;

  typedef enum int {M_NONE, M_RESP, M_SILENT, M_DOUBLE, M_LATE, M_RSTD} eng_mode_t;
  typedef struct { int slot; int gap; bit fd; } launch_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  enable_mask;
  logic        eng_launch;
  logic [6:0]  eng_addr;
  logic        eng_done;
  logic [15:0] eng_dist;
  logic [1:0]  rd_idx;
  logic [31:0] rd_data;
  logic [1:0]  cur_slot;
  logic        frame_done;

  sonar_scheduler #(
    .N_SONAR        (N),
    .ADDR_BASE      (7'h70),
    .RANGE_CYCLES   (RC),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable_mask (enable_mask),
    .eng_launch  (eng_launch),
    .eng_addr    (eng_addr),
    .eng_done    (eng_done),
    .eng_dist    (eng_dist),
    .rd_idx      (rd_idx),
    .rd_data     (rd_data),
    .cur_slot    (cur_slot),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  launch_t   exp_q[$];
  int        launch_cnt      = 0;
  int        last_launch_cyc = 0;
  int        launch_cyc      = 0;
  int        mdl_slot        = 0;
  event      launch_ev;
  eng_mode_t eng_mode        = M_NONE;
  bit        use_fixed       = 1'b0;

  // Reference result registers
  logic [15:0] m_dist[N];
  bit          m_valid[N];
  bit          m_err[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_dist[i] = '0; m_valid[i] = 1'b0; m_err[i] = 1'b0;
    end
  endtask

  task automatic model_store(input int s, input logic [15:0] v);
    m_dist[s] = v; m_valid[s] = 1'b1; m_err[s] = 1'b0;
  endtask

  task automatic push(input int slot, input int gap, input bit fd);
    launch_t e;
    e.slot = slot; e.gap = gap; e.fd = fd;
    exp_q.push_back(e);
  endtask

  // Launch monitor: pop expected launch and compare address, slot, spacing, frame flag
  always @(negedge clk) begin
    launch_t e;
    if (eng_launch) begin
      launch_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_launch: got launch on addr 0x%02h, required none", eng_addr);
        mdl_slot = 0;
      end else begin
        e = exp_q.pop_front();
        chk("launch_addr", 32'(eng_addr), 32'(7'h70 + e.slot));
        chk("launch_cur_slot", 32'(cur_slot), 32'(e.slot));
        chk("launch_frame_done", 32'(frame_done), 32'(e.fd));
        if (e.gap >= 0) chk("launch_gap", 32'(cyc - last_launch_cyc), 32'(e.gap));
        mdl_slot = e.slot;
      end
      last_launch_cyc = cyc;
      launch_cyc      = cyc;
      -> launch_ev;
    end
  end

  task automatic pulse(input logic [15:0] v);
    eng_done = 1'b1; eng_dist = v;
    @(negedge clk);
    eng_done = 1'b0; eng_dist = 16'($urandom);
  endtask

  // Engine model: answers each launch according to the current mode
  initial begin
    eng_mode_t   m;
    int          s;
    logic [15:0] v;
    eng_done = 1'b0;
    eng_dist = '0;
    forever begin
      @(launch_ev);
      m = eng_mode;
      s = mdl_slot;
      v = use_fixed ? 16'(100 + s) : 16'($urandom);
      case (m)
        M_RESP:   begin repeat (5) @(negedge clk); model_store(s, v); pulse(v); end
        M_SILENT: begin repeat (TC) @(negedge clk); m_err[s] = 1'b1; m_valid[s] = 1'b0; end
        M_DOUBLE: begin
          repeat (5) @(negedge clk); model_store(s, v); pulse(v);
          @(negedge clk); pulse(v ^ 16'h5a5a);
        end
        M_LATE:   begin repeat (TC) @(negedge clk); model_store(s, v); pulse(v); end
        M_RSTD:   begin repeat (3) @(negedge clk); pulse(v); end
        default:  ;
      endcase
    end
  end

  task automatic wait_launches(input int n);
    int budget = 200;
    while (launch_cnt < n && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    if (launch_cnt < n) begin
      n_checks++;
      $display("FAIL wait_launch: got %0d launches, required %0d", launch_cnt, n);
    end
  endtask

  task automatic rd_check(input int idx);
    logic [31:0] e;
    @(negedge clk); rd_idx = 2'(idx);
    @(negedge clk);
    e = {m_err[idx], m_valid[idx], 14'b0, m_dist[idx]};
    chk($sformatf("rd_data[%0d]", idx), rd_data, e);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0; enable_mask = '0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got no finish, required finish before 200 us");
    $fatal(1);
  end

  initial begin
    int base;
    int rel;
    reset = 1'b0; enable_mask = 4'b1111; rd_idx = '0;
    model_clear();

    // Basic rotation with fixed distances 100+k
    use_fixed = 1'b1; eng_mode = M_RESP;
    repeat (3) @(negedge clk);
    chk("reset_eng_launch", 32'(eng_launch), 32'd0);
    chk("reset_eng_addr", 32'(eng_addr), 32'h70);
    chk("reset_cur_slot", 32'(cur_slot), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    push(0, -1, 0); push(1, GAP_OK, 0); push(2, GAP_OK, 0); push(3, GAP_OK, 0); push(0, GAP_OK, 1);
    reset = 1'b1; rel = cyc;
    wait_launches(1);
    chk("first_launch_cycle", 32'(launch_cyc - rel + 1), 32'd2);
    wait_launches(5);
    enable_mask = '0;
    repeat (RC + 20) @(negedge clk);
    for (int i = 0; i < N; i++) rd_check(i);

    // Timeout on a single silent slot
    use_fixed = 1'b0;
    do_reset();
    eng_mode = M_SILENT; base = launch_cnt;
    push(1, -1, 0); push(1, GAP_TO, 1); push(1, GAP_TO, 1);
    enable_mask = 4'b0010;
    wait_launches(base + 2);
    rd_check(1);
    wait_launches(base + 3);
    enable_mask = '0;
    repeat (TC + 10) @(negedge clk);
    rd_check(0);
    rd_check(1);

    // Sparse mask
    do_reset();
    eng_mode = M_RESP; base = launch_cnt;
    push(0, -1, 0); push(3, GAP_OK, 0); push(0, GAP_OK, 1);
    enable_mask = 4'b1001;
    wait_launches(base + 3);
    enable_mask = '0;
    repeat (RC + 20) @(negedge clk);
    for (int i = 0; i < N; i++) rd_check(i);

    // Mask change during slot 0's wait, then mask to zero
    do_reset();
    base = launch_cnt;
    push(0, -1, 0); push(2, GAP_OK, 0);
    enable_mask = 4'b1111;
    wait_launches(base + 1);
    repeat (3) @(negedge clk);
    enable_mask = 4'b0100;
    wait_launches(base + 2);
    enable_mask = '0;
    repeat (RC + 20) @(negedge clk);
    for (int i = 0; i < N; i++) rd_check(i);

    // Reset for one cycle mid-wait, coinciding with eng_done
    eng_mode = M_RSTD; base = launch_cnt;
    push(0, -1, 0);
    enable_mask = 4'b1111;
    wait_launches(base + 1);
    repeat (3) @(negedge clk);
    reset = 1'b0; eng_mode = M_SILENT;
    model_clear();
    push(0, -1, 0);
    @(negedge clk);
    reset = 1'b1; rel = cyc;
    wait_launches(base + 2);
    chk("reset_relaunch_cycle", 32'(launch_cyc - rel + 1), 32'd2);
    for (int i = 0; i < N; i++) rd_check(i);
    enable_mask = '0;
    repeat (TC + 10) @(negedge clk);

    // Double done in one wait, then done in the final timeout cycle
    do_reset();
    eng_mode = M_DOUBLE; base = launch_cnt;
    push(0, -1, 0); push(0, GAP_OK, 1); push(0, GAP_TO, 1);
    enable_mask = 4'b0001;
    wait_launches(base + 1);
    eng_mode = M_LATE;
    wait_launches(base + 2);
    eng_mode = M_RESP;
    rd_check(0);
    wait_launches(base + 3);
    enable_mask = '0;
    rd_check(0);
    repeat (RC + 20) @(negedge clk);
    rd_check(0);

    chk("pending_launches", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
